// File: rtl/csr_bridge_pkg.sv
// Shared constants and state encoding for the byte-stream to CSR bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package csr_bridge_pkg;

    // Command opcodes carried in the first byte of every frame
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    // Single-byte status responses
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_RESP
    } state_t;

endpackage

// File: rtl/csr_cmd_bridge.sv
// Parses write/read command frames from a byte stream, drives the CSR bus, returns ACK/NAK or 4 read bytes.
// Latency: write ACK 2 cycles after last data byte; read data 3 cycles after last address byte; NAK next cycle.
// Backpressure: in_ready low outside IDLE/ADDR/DATA; response byte held stable until out_ready.
// Optional: define CSR_BRIDGE_TIMEOUT_EN to drop frames stalled for TIMEOUT_CYCLES idle cycles.
module csr_cmd_bridge
    import csr_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_write,
    input  logic [31:0] csr_rdata
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic        is_wr;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;
    logic [23:0] rsp_sr;
    logic [1:0]  rsp_left;
    logic        in_acc;
    logic        out_acc;
    logic        tmo_hit;

    assign in_ready = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    // Parameter sanity marker: an illegal TIMEOUT_CYCLES (< 2) leaves this block in the hierarchy
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_illegal
    end

`ifdef CSR_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Inter-byte idle counter: runs only while a frame is being collected
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if ((state == ST_ADDR || state == ST_DATA) && !in_acc && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
    assign tmo_hit = (state == ST_ADDR || state == ST_DATA) && !in_acc &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode for the frame parser and response serializer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_acc) begin
                    if (in_data == OP_WRITE || in_data == OP_READ) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (tmo_hit) begin
                    state_nxt = ST_RESP;
                end else if (in_acc && byte_cnt == 2'd3) begin
                    state_nxt = is_wr ? ST_DATA : ST_RD_WAIT;
                end
            end
            ST_DATA: begin
                if (tmo_hit) begin
                    state_nxt = ST_RESP;
                end else if (in_acc && byte_cnt == 2'd3) begin
                    state_nxt = ST_WR;
                end
            end
            ST_WR:      state_nxt = ST_RESP;
            ST_RD_WAIT: state_nxt = ST_RD_CAP;
            ST_RD_CAP:  state_nxt = ST_RESP;
            ST_RESP: begin
                if (out_acc && rsp_left == 2'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Field shift registers, CSR bus registers and response byte register.
    // Write frames commit address and data together on the last data byte so a
    // truncated write never moves csr_addr; read frames commit on the last address byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt  <= 2'd0;
            is_wr     <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            rsp_sr    <= '0;
            rsp_left  <= 2'd0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            csr_write <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            csr_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_acc) begin
                        byte_cnt <= 2'd0;
                        is_wr    <= (in_data == OP_WRITE);
                        if (in_data != OP_WRITE && in_data != OP_READ) begin
                            out_valid <= 1'b1;
                            out_data  <= RSP_NAK;
                            rsp_left  <= 2'd0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (tmo_hit) begin
                        byte_cnt  <= 2'd0;
                        out_valid <= 1'b1;
                        out_data  <= RSP_NAK;
                        rsp_left  <= 2'd0;
                    end else if (in_acc) begin
                        addr_sr  <= {addr_sr[23:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 && !is_wr) begin
                            csr_addr <= {addr_sr[23:0], in_data};
                        end
                    end
                end
                ST_DATA: begin
                    if (tmo_hit) begin
                        byte_cnt  <= 2'd0;
                        out_valid <= 1'b1;
                        out_data  <= RSP_NAK;
                        rsp_left  <= 2'd0;
                    end else if (in_acc) begin
                        data_sr  <= {data_sr[23:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            csr_addr  <= addr_sr;
                            csr_wdata <= {data_sr[23:0], in_data};
                            csr_write <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    out_valid <= 1'b1;
                    out_data  <= RSP_ACK;
                    rsp_left  <= 2'd0;
                end
                ST_RD_CAP: begin
                    out_valid <= 1'b1;
                    out_data  <= csr_rdata[31:24];
                    rsp_sr    <= csr_rdata[23:0];
                    rsp_left  <= 2'd3;
                end
                ST_RESP: begin
                    if (out_acc) begin
                        if (rsp_left == 2'd0) begin
                            out_valid <= 1'b0;
                        end else begin
                            out_data <= rsp_sr[23:16];
                            rsp_sr   <= {rsp_sr[15:0], 8'h00};
                            rsp_left <= rsp_left - 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_cmd_bridge.sv
module tb_csr_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_write;
    logic [31:0] csr_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0]  sb[$];          // expected response bytes
    logic [63:0] wq[$];          // expected {addr, wdata} CSR writes
    logic [31:0] regs   [16];    // peripheral register file written by the DUT
    logic [31:0] shadow [16];    // what the bench expects the register file to hold

    always #5 clk = ~clk;

    csr_cmd_bridge #(.TIMEOUT_CYCLES(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_write (csr_write),
        .csr_rdata (csr_rdata)
    );

    assign csr_rdata = regs[csr_addr[3:0]];

    always @(posedge clk) begin
        if (csr_write) regs[csr_addr[3:0]] <= csr_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response scoreboard: every byte the host takes must be the next expected one
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rsp_byte", {24'h0, out_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    // CSR write scoreboard
    always @(negedge clk) begin
        if (csr_write) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", csr_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] w;
                w = wq.pop_front();
                chk("wr_addr", csr_addr, w[63:32]);
                chk("wr_data", csr_wdata, w[31:0]);
            end
        end
    end

    // Offer one byte; returns #1 after the edge that accepted it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send_write(input logic [3:0] a, input logic [31:0] d);
        sb.push_back(8'h06);
        wq.push_back({28'h0, a, d});
        shadow[a] = d;
        send_byte(8'h57);
        send_word({28'h0, a});
        send_word(d);
        // cycle N+1: strobe with bus already stable
        chk("wr_strobe", {31'h0, csr_write}, 1);
        chk("wr_bus_addr", csr_addr, {28'h0, a});
        chk("wr_bus_data", csr_wdata, d);
        @(posedge clk); #1;
        // cycle N+2: single-cycle strobe, ACK presented
        chk("wr_strobe_off", {31'h0, csr_write}, 0);
        chk("ack_valid", {31'h0, out_valid}, 1);
        chk("ack_byte", {24'h0, out_data}, 32'h06);
        drain();
    endtask

    task automatic send_read(input logic [3:0] a);
        logic [31:0] e;
        e = shadow[a];
        for (int i = 3; i >= 0; i--) sb.push_back(e[i*8 +: 8]);
        send_byte(8'h52);
        send_word({28'h0, a});
        chk("rd_addr", csr_addr, {28'h0, a});          // N+1
        chk("rd_in_ready", {31'h0, in_ready}, 0);
        @(posedge clk); #1;
        chk("rd_wait_valid", {31'h0, out_valid}, 0);   // N+2
        for (int i = 0; i < 4; i++) begin               // N+3..N+6
            @(posedge clk); #1;
            chk("rd_stream_valid", {31'h0, out_valid}, 1);
        end
        @(posedge clk); #1;
        chk("rd_done_valid", {31'h0, out_valid}, 0);
        drain();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs[i]   = 32'h0;
            shadow[i] = 32'h0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", csr_addr, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_write", {31'h0, csr_write}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_data", {24'h0, out_data}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 1);
        rst = 1'b1;

        // Basic write then readback
        send_write(4'h0, 32'h0000_0005);
        send_read(4'h0);

        // Bad opcode gives NAK in the very next cycle, no CSR write
        sb.push_back(8'h15);
        send_byte(8'hAA);
        chk("nak_valid", {31'h0, out_valid}, 1);
        chk("nak_byte", {24'h0, out_data}, 32'h15);
        chk("nak_no_write", {31'h0, csr_write}, 0);
        drain();
        send_write(4'h3, 32'hDEAD_BEEF);
        send_read(4'h3);

        // Host backpressure during a read response
        begin
            logic [7:0] d0;
            logic       ok;
            int         n;
            out_ready = 1'b0;
            for (int i = 3; i >= 0; i--) sb.push_back(shadow[3][i*8 +: 8]);
            send_byte(8'h52);
            send_word(32'h3);
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("stall_valid", {31'h0, out_valid}, 1);
            d0 = out_data;
            ok = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (out_data !== d0 || !out_valid || in_ready) ok = 1'b0;
            end
            chk("stall_stable", {31'h0, ok}, 1);
            chk("stall_first_byte", {24'h0, d0}, {24'h0, shadow[3][31:24]});
            out_ready = 1'b1;
            drain();
        end

        // Reset in the middle of a write frame's address field
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_addr", csr_addr, 0);
        chk("mid_rst_wdata", csr_wdata, 0);
        chk("mid_rst_write", {31'h0, csr_write}, 0);
        chk("mid_rst_valid", {31'h0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'h0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b1;
        send_write(4'h1, 32'hA5A5_1234);
        send_read(4'h1);

`ifdef CSR_BRIDGE_TIMEOUT_EN
        // Stall mid address field: frame dropped with NAK, bus untouched
        begin
            logic [31:0] a0;
            a0 = csr_addr;
            sb.push_back(8'h15);
            send_byte(8'h52);
            send_byte(8'h00);
            send_byte(8'h00);
            drain();
            @(negedge clk);
            chk("tmo_addr_kept", csr_addr, a0);
            chk("tmo_idle", {31'h0, in_ready}, 1);
            send_write(4'h2, 32'h0102_0304);
            send_read(4'h2);
        end
`endif

        repeat (5) @(negedge clk);
        chk("final_rsp_q", sb.size(), 0);
        chk("final_wr_q", wq.size(), 0);
        chk("final_regs", regs[1], shadow[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute backstop so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
